node_injection_scheduler: RTL and testbench

- Per-node injection controller between a node's local sources and its network input port.
- Arbitrates two requesters onto the single `packet_t` network input:
  - data packets, from the node queue;
  - ant packets, from the ant generator.
- Holds the granted packet in a one-entry output register.
- Sequences the run through IDLE/WARMUP/MEASURE/DRAIN/DONE by counting data packets the network accepts; the bench uses this to bracket the measurement window.

---
 rtl/node_injection_scheduler_pkg.sv | 19 +
 rtl/node_injection_scheduler_arbiter.sv | 26 ++
 rtl/node_injection_scheduler.sv | 77 +++++++
 tb/tb_node_injection_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/node_injection_scheduler_pkg.sv
// node_injection_scheduler_pkg: shared packet type, phase encoding and default thresholds
package node_injection_scheduler_pkg;
  typedef struct packed {
    logic        ant;
    logic [3:0]  dst;
    logic [15:0] payload;
  } packet_t;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WARMUP  = 3'd1,
    MEASURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } phase_t;
  localparam int WARMUP_PACKETS_DEF  = 1000;
  localparam int MEASURE_PACKETS_DEF = 5000;
  localparam int DRAIN_PACKETS_DEF   = 3000;
  localparam int STARVE_LIMIT_DEF    = 4;
endpackage

// File: rtl/node_injection_scheduler_arbiter.sv
// inj_arbiter_2to1: ant-priority grant between data and ant with a data starvation override
module inj_arbiter_2to1 import node_injection_scheduler_pkg::*; #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_val,
  input  logic a_val,
  input  logic load_ok,
  output logic d_rdy,
  output logic a_rdy
);
  localparam int SW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic starved, d_gnt;
  assign starved = int'(starve_cnt) >= STARVE_LIMIT;
  assign d_gnt   = d_val && (!a_val || starved);
  assign d_rdy   = load_ok && d_gnt;
  assign a_rdy   = load_ok && a_val && !d_gnt;
  // count data cycles lost to ant while the output could load, saturating at the limit
  always_ff @(posedge clk) begin
    if (!reset_n) starve_cnt <= '0;
    else if (d_rdy) starve_cnt <= '0;
    else if (d_val && load_ok && !starved) starve_cnt <= starve_cnt + 1'b1;
  end
endmodule

// File: rtl/node_injection_scheduler.sv
// node_injection_scheduler: injection arbiter, output register and run-phase FSM (option INJ_MEASURE_CYCLES_EN)
module node_injection_scheduler import node_injection_scheduler_pkg::*; #(
  parameter int WARMUP_PACKETS  = WARMUP_PACKETS_DEF,
  parameter int MEASURE_PACKETS = MEASURE_PACKETS_DEF,
  parameter int DRAIN_PACKETS   = DRAIN_PACKETS_DEF,
  parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  packet_t          d_data,
  input  logic             d_val,
  output logic             d_rdy,
  input  packet_t          a_data,
  input  logic             a_val,
  output logic             a_rdy,
  output packet_t          net_data,
  output logic             net_val,
  input  logic             net_en,
  output logic [2:0]       phase,
  output logic             measuring,
  output logic             done,
  output logic [CNT_W-1:0] measure_cycles
);
  phase_t phase_q;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic active, xfer, load_ok, counted, pass;
  assign active  = phase_q inside {WARMUP, MEASURE, DRAIN};
  assign xfer    = net_val && net_en;
  assign load_ok = reset_n && active && (!net_val || xfer);
  assign counted = xfer && active && !net_data.ant;
  assign cnt_nxt = cnt + CNT_W'(counted);
  assign pass    = phase_q == WARMUP  ? cnt_nxt >= CNT_W'(WARMUP_PACKETS)  :
                   phase_q == MEASURE ? cnt_nxt >= CNT_W'(MEASURE_PACKETS) :
                   phase_q == DRAIN   ? cnt_nxt >= CNT_W'(DRAIN_PACKETS)   : 1'b0;
  assign phase     = phase_q;
  assign measuring = phase_q == MEASURE;
  assign done      = phase_q == DONE;
  inj_arbiter_2to1 #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .clk(clk), .reset_n(reset_n), .d_val(d_val), .a_val(a_val),
    .load_ok(load_ok), .d_rdy(d_rdy), .a_rdy(a_rdy)
  );
  // phase sequencing on accepted data packets; a crossing handshake counts toward the old phase
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q <= IDLE;
      cnt     <= '0;
    end else if (phase_q == IDLE) begin
      if (start) phase_q <= WARMUP;
    end else if (active) begin
      cnt <= pass ? '0 : cnt_nxt;
      if (pass) phase_q <= phase_t'(phase_q + 3'd1);
    end
  end
  // one-entry output register, reloadable on the cycle it drains
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      net_val  <= 1'b0;
      net_data <= '0;
    end else if (d_rdy || a_rdy) begin
      net_val  <= 1'b1;
      net_data <= d_rdy ? d_data : a_data;
    end else if (xfer) begin
      net_val  <= 1'b0;
    end
  end
`ifdef INJ_MEASURE_CYCLES_EN
  // saturating count of cycles spent in MEASURE, held afterwards
  always_ff @(posedge clk) begin
    if (!reset_n) measure_cycles <= '0;
    else if (measuring && !(&measure_cycles)) measure_cycles <= measure_cycles + 1'b1;
  end
`else
  assign measure_cycles = '0;
`endif
endmodule

// File: tb/tb_node_injection_scheduler.sv
// tb_node_injection_scheduler: directed and random stimulus against a cycle reference model
module tb_node_injection_scheduler;
  import node_injection_scheduler_pkg::*;
  localparam int W = 2, M = 3, D = 2, SL = 2;
  logic clk = 1'b0;
  logic reset_n, start, d_val, a_val, net_en;
  packet_t d_data, a_data, net_data;
  logic d_rdy, a_rdy, net_val, measuring, done;
  logic [2:0] phase;
  logic [31:0] measure_cycles;
  int checks = 0, errors = 0;
  int thr[5] = '{0, W, M, D, 0};
  int m_phase, m_cnt, m_starve, m_val, total_data;
  int unsigned m_mc;
  packet_t m_pkt;
  logic s_d, s_a;
  node_injection_scheduler #(
    .WARMUP_PACKETS(W), .MEASURE_PACKETS(M), .DRAIN_PACKETS(D), .STARVE_LIMIT(SL), .CNT_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .d_data(d_data), .d_val(d_val), .d_rdy(d_rdy),
    .a_data(a_data), .a_val(a_val), .a_rdy(a_rdy),
    .net_data(net_data), .net_val(net_val), .net_en(net_en),
    .phase(phase), .measuring(measuring), .done(done), .measure_cycles(measure_cycles)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_starve = 0; m_val = 0; m_pkt = '0; m_mc = 0;
  endtask
  function automatic int exp_mc();
`ifdef INJ_MEASURE_CYCLES_EN
    return int'(m_mc);
`else
    return 0;
`endif
  endfunction
  task automatic tick();
    bit act, xf, room, dg, ag;
    d_data = packet_t'({1'b0, 20'($urandom)});
    a_data = packet_t'({1'b1, 20'($urandom)});
    #2;
    act  = m_phase >= 1 && m_phase <= 3;
    xf   = m_val != 0 && net_en;
    room = reset_n && act && (m_val == 0 || xf);
    dg = 0; ag = 0;
    if (room && d_val && (!a_val || m_starve >= SL)) dg = 1;
    else if (room && a_val) ag = 1;
    s_d = d_rdy; s_a = a_rdy;
    chk("d_rdy", 32'(d_rdy), 32'(dg));
    chk("a_rdy", 32'(a_rdy), 32'(ag));
    chk("net_val", 32'(net_val), 32'(m_val));
    if (m_val != 0) chk("net_data", 32'(net_data), 32'(m_pkt));
    chk("phase", 32'(phase), 32'(m_phase));
    chk("measuring", 32'(measuring), 32'(m_phase == 2));
    chk("done", 32'(done), 32'(m_phase == 4));
    chk("measure_cycles", measure_cycles, 32'(exp_mc()));
    @(posedge clk);
    if (!reset_n) model_reset();
    else begin
      if (m_phase == 2 && m_mc != 32'hFFFF_FFFF) m_mc++;
      if (m_phase == 0) begin
        if (start) m_phase = 1;
      end else if (act) begin
        if (xf && !m_pkt.ant) begin m_cnt++; total_data++; end
        if (m_cnt >= thr[m_phase]) begin m_phase++; m_cnt = 0; end
      end
      if (dg) m_starve = 0;
      else if (d_val && room && m_starve < SL) m_starve++;
      if (dg) begin m_pkt = d_data; m_val = 1; end
      else if (ag) begin m_pkt = a_data; m_val = 1; end
      else if (xf) m_val = 0;
    end
    #1;
  endtask
  task automatic restart();
    reset_n = 1'b0; start = 1'b0; tick();
    reset_n = 1'b1; start = 1'b1; tick();
    start = 1'b0; total_data = 0;
  endtask
  initial begin
    logic [1:0] gexp [6];
    gexp = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    reset_n = 1'b0; start = 1'b0; d_val = 1'b0; a_val = 1'b0; net_en = 1'b0;
    d_data = '0; a_data = '0;
    @(posedge clk); #1;
    model_reset();
    total_data = 0;
    tick();
    chk("reset_phase", 32'(phase), 32'(IDLE));
    chk("reset_net_val", 32'(net_val), 0);
    chk("reset_net_data", 32'(net_data), 0);
    // continuous data through all phases
    d_val = 1'b1; a_val = 1'b0; net_en = 1'b1;
    tick();
    chk("idle_backpressure", 32'(d_rdy), 0);
    restart();
    chk("enter_warmup", 32'(phase), 32'(WARMUP));
    for (int i = 0; i < 60 && m_phase != 4; i++) tick();
    chk("reach_done", 32'(phase), 32'(DONE));
    chk("data_count", 32'(total_data), 32'(W + M + D));
    tick();
    chk("done_no_grant", 32'(d_rdy), 0);
    // both requesters: starvation override pattern
    a_val = 1'b1; d_val = 1'b1; net_en = 1'b1;
    restart();
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("grant_seq", 32'({s_d, s_a}), 32'(gexp[i]));
    end
    chk("ant_not_counted", 32'(phase), 32'(WARMUP));
    // stall in MEASURE, ignored start, measured cycle count
    a_val = 1'b0; d_val = 1'b1; net_en = 1'b1;
    restart();
    for (int i = 0; i < 40 && m_phase != 2; i++) tick();
    chk("enter_measure", 32'(phase), 32'(MEASURE));
    net_en = 1'b0;
    for (int i = 0; i < 34; i++) begin
      start = (i == 3);
      tick();
    end
    start = 1'b0;
    chk("start_ignored", 32'(phase), 32'(MEASURE));
    net_en = 1'b1;
    for (int i = 0; i < 40 && m_phase != 4; i++) tick();
    chk("done_after_stall", 32'(phase), 32'(DONE));
`ifdef INJ_MEASURE_CYCLES_EN
    chk("measure_37", measure_cycles, 37);
`else
    chk("measure_off", measure_cycles, 0);
`endif
    for (int i = 0; i < 3; i++) tick();
    // reset mid-MEASURE with a held packet
    restart();
    for (int i = 0; i < 40 && m_phase != 2; i++) tick();
    net_en = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; a_val = 1'b1;
    tick();
    chk("rst_phase", 32'(phase), 32'(IDLE));
    chk("rst_net_val", 32'(net_val), 0);
    chk("rst_mc", measure_cycles, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("rst_no_grant", 32'({d_rdy, a_rdy}), 0);
    // randomized runs
    for (int r = 0; r < 8; r++) begin
      restart();
      for (int i = 0; i < 80; i++) begin
        d_val  = 1'($urandom_range(0, 1));
        a_val  = 1'($urandom_range(0, 1));
        net_en = $urandom_range(0, 9) < 7;
        start  = $urandom_range(0, 19) == 0;
        reset_n = $urandom_range(0, 149) != 0;
        tick();
      end
      reset_n = 1'b1; start = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
